// File: rtl/ccip_c1_write_arbiter.sv
// Round-robin CCI-P TX C1 write arbiter with packet lock, credit limit and completion routing.
// Optional perf counters: define CCIP_C1_WRITE_ARBITER_PERF_EN.
module ccip_c1_write_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ID_W      = 3,
    parameter int HDR_W     = 99,
    parameter int DATA_W    = 512,
    parameter int BE_W      = 64,
    parameter int MAX_OUTST = 64,
    parameter int CNT_W     = 7
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*HDR_W-1:0]  req_header,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*BE_W-1:0]   req_byteen,
    input  logic                      ci0_tx_c1_almostfull,
    output logic [HDR_W-1:0]          ci0_tx_c1_header,
    output logic [DATA_W-1:0]         ci0_tx_c1_data,
    output logic [BE_W-1:0]           ci0_tx_c1_byteen,
    output logic                      ci0_tx_c1_wrvalid,
    input  logic [27:0]               ci0_rx_c1_header,
    input  logic                      ci0_rx_c1_wrvalid,
    output logic [NUM_REQ-1:0]        rsp_wrvalid,
    output logic [CNT_W-1:0]          wr_outstanding,
    output logic                      ci0_nohazards_wr_all,
    output logic                      err_underflow,
    output logic [31:0]               perf_stall_cnt,
    output logic [31:0]               perf_beat_cnt
);

    localparam int SUM_W = CNT_W + 1;

    typedef enum logic {
        S_IDLE,
        S_LOCK
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   lock_q, lock_d;

    logic [SUM_W-1:0]  inflight;
    logic              can_issue;
    logic [NUM_REQ-1:0] upper, pick_oh, lock_oh, grant_oh;
    logic              found;
    logic              accept;
    logic [ID_W-1:0]   gnt_idx;
    logic              last_sel;
    logic [HDR_W-1:0]  hdr_sel;
    logic [DATA_W-1:0] data_sel;
    logic [BE_W-1:0]   be_sel;

    logic              tx_valid_q;
    logic [HDR_W-1:0]  tx_hdr_q;
    logic [DATA_W-1:0] tx_data_q;
    logic [BE_W-1:0]   tx_be_q;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              under_q, under_d;
    logic              nohaz_q;

    // The registered beat on the channel is not yet in the counter
    assign inflight  = {1'b0, cnt_q} + SUM_W'(tx_valid_q);
    assign can_issue = !ci0_tx_c1_almostfull && (inflight < SUM_W'(MAX_OUTST));

    always_comb begin
        upper   = '0;
        pick_oh = '0;
        lock_oh = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            upper[i]   = (ID_W'(i) >= ptr_q);
            lock_oh[i] = (ID_W'(i) == lock_q);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && upper[i]) begin
                pick_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                pick_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        case (state_q)
            S_LOCK:  grant_oh = lock_oh & req_valid & {NUM_REQ{can_issue}};
            default: grant_oh = pick_oh & {NUM_REQ{can_issue}};
        endcase
    end

    assign req_ready = grant_oh & {NUM_REQ{!reset_reset}};
    assign accept    = |req_ready;

    always_comb begin
        gnt_idx  = '0;
        last_sel = 1'b0;
        hdr_sel  = '0;
        data_sel = '0;
        be_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                gnt_idx  = ID_W'(i);
                last_sel = req_last[i];
                hdr_sel  = req_header[i*HDR_W +: HDR_W];
                data_sel = req_data[i*DATA_W +: DATA_W];
                be_sel   = req_byteen[i*BE_W +: BE_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        if (accept) begin
            if (last_sel) begin
                state_d = S_IDLE;
                ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            end else begin
                state_d = S_LOCK;
                lock_d  = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            tx_valid_q <= 1'b0;
            tx_hdr_q   <= '0;
            tx_data_q  <= '0;
            tx_be_q    <= '0;
        end else begin
            tx_valid_q <= accept;
            if (accept) begin
                tx_hdr_q  <= {hdr_sel[HDR_W-1:ID_W], gnt_idx};
                tx_data_q <= data_sel;
                tx_be_q   <= be_sel;
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        under_d = under_q;
        case ({tx_valid_q, ci0_rx_c1_wrvalid})
            2'b10: cnt_d = cnt_q + CNT_W'(1);
            2'b01: begin
                if (cnt_q == '0) under_d = 1'b1;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Computed from next-state values so it matches the registered count and strobe
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            cnt_q   <= '0;
            under_q <= 1'b0;
            nohaz_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            under_q <= under_d;
            nohaz_q <= (cnt_d == '0) && !accept;
        end
    end

    always_comb begin
        rsp_wrvalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_wrvalid[i] = ci0_rx_c1_wrvalid && !reset_reset &&
                             (ci0_rx_c1_header[ID_W-1:0] == ID_W'(i));
        end
    end

    assign ci0_tx_c1_wrvalid    = tx_valid_q;
    assign ci0_tx_c1_header     = tx_hdr_q;
    assign ci0_tx_c1_data       = tx_data_q;
    assign ci0_tx_c1_byteen     = tx_be_q;
    assign wr_outstanding       = cnt_q;
    assign ci0_nohazards_wr_all = nohaz_q;
    assign err_underflow        = under_q;

    logic unused_bits;
    assign unused_bits = ^{ci0_rx_c1_header[27:ID_W], hdr_sel[ID_W-1:0]};

`ifdef CCIP_C1_WRITE_ARBITER_PERF_EN
    logic [31:0] stall_q, beat_q;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            stall_q <= '0;
            beat_q  <= '0;
        end else begin
            if ((|req_valid) && !can_issue) stall_q <= stall_q + 32'd1;
            if (tx_valid_q)                 beat_q  <= beat_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_beat_cnt  = beat_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_beat_cnt  = '0;
`endif

endmodule

// File: tb/tb_ccip_c1_write_arbiter.sv
// Directed self-checking bench for ccip_c1_write_arbiter (NUM_REQ=2, MAX_OUTST=64).
// Checks arbitration order, packet lock, backpressure, credit limit, routing and reset.
module tb_ccip_c1_write_arbiter;

    localparam int NR = 2;
    localparam int HW = 99;
    localparam int DW = 512;
    localparam int BW = 64;

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic [NR-1:0]     req_valid, req_ready, req_last;
    logic [NR*HW-1:0]  req_header;
    logic [NR*DW-1:0]  req_data;
    logic [NR*BW-1:0]  req_byteen;
    logic              ci0_tx_c1_almostfull;
    logic [HW-1:0]     ci0_tx_c1_header;
    logic [DW-1:0]     ci0_tx_c1_data;
    logic [BW-1:0]     ci0_tx_c1_byteen;
    logic              ci0_tx_c1_wrvalid;
    logic [27:0]       ci0_rx_c1_header;
    logic              ci0_rx_c1_wrvalid;
    logic [NR-1:0]     rsp_wrvalid;
    logic [6:0]        wr_outstanding;
    logic              ci0_nohazards_wr_all;
    logic              err_underflow;
    logic [31:0]       perf_stall_cnt, perf_beat_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int exp_beats = 0;

    always #5 clk_clk = ~clk_clk;

    ccip_c1_write_arbiter dut (
        .clk_clk              (clk_clk),
        .reset_reset          (reset_reset),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_last             (req_last),
        .req_header           (req_header),
        .req_data             (req_data),
        .req_byteen           (req_byteen),
        .ci0_tx_c1_almostfull (ci0_tx_c1_almostfull),
        .ci0_tx_c1_header     (ci0_tx_c1_header),
        .ci0_tx_c1_data       (ci0_tx_c1_data),
        .ci0_tx_c1_byteen     (ci0_tx_c1_byteen),
        .ci0_tx_c1_wrvalid    (ci0_tx_c1_wrvalid),
        .ci0_rx_c1_header     (ci0_rx_c1_header),
        .ci0_rx_c1_wrvalid    (ci0_rx_c1_wrvalid),
        .rsp_wrvalid          (rsp_wrvalid),
        .wr_outstanding       (wr_outstanding),
        .ci0_nohazards_wr_all (ci0_nohazards_wr_all),
        .err_underflow        (err_underflow),
        .perf_stall_cnt       (perf_stall_cnt),
        .perf_beat_cnt        (perf_beat_cnt)
    );

    function automatic logic [HW-1:0] mk_hdr(int i, int n);
        return (HW'(32'hC0DE_0000 | (i << 12) | n) << 3) | HW'(7);
    endfunction

    function automatic logic [HW-1:0] exp_hdr(int i, int n);
        return (mk_hdr(i, n) & ~HW'(7)) | HW'(i);
    endfunction

    function automatic logic [127:0] mk_data(int i, int n);
        return 128'(i * 65536 + n + 1);
    endfunction

    function automatic logic [BW-1:0] mk_be(int i, int n);
        return BW'(i * 256 + n + 3);
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic set_beat(int i, int n, logic v, logic l);
        req_valid[i]               = v;
        req_last[i]                = l;
        req_header[i*HW +: HW]     = mk_hdr(i, n);
        req_data[i*DW +: DW]       = DW'(mk_data(i, n));
        req_byteen[i*BW +: BW]     = mk_be(i, n);
    endtask

    task automatic chk_tx(string tag, int i, int n);
        exp_beats++;
        chk({tag, "_wv"}, 128'(ci0_tx_c1_wrvalid), 128'(1));
        chk({tag, "_hdr"}, 128'(ci0_tx_c1_header), 128'(exp_hdr(i, n)));
        chk({tag, "_dat"}, ci0_tx_c1_data[127:0], mk_data(i, n));
        chk({tag, "_be"}, 128'(ci0_tx_c1_byteen), 128'(mk_be(i, n)));
    endtask

    task automatic drain(int n, int id);
        for (int k = 0; k < n; k++) begin
            ci0_rx_c1_header  = 28'h5A5_0000 | 28'(id);
            ci0_rx_c1_wrvalid = 1'b1;
            #1;
            chk("rsp_route", 128'(rsp_wrvalid), (id < NR) ? 128'(1 << id) : 128'(0));
            tick();
        end
        ci0_rx_c1_wrvalid = 1'b0;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_wv"}, 128'(ci0_tx_c1_wrvalid), 128'(0));
        chk({tag, "_hdr"}, 128'(ci0_tx_c1_header), 128'(0));
        chk({tag, "_dat"}, ci0_tx_c1_data[127:0], 128'(0));
        chk({tag, "_be"}, 128'(ci0_tx_c1_byteen), 128'(0));
        chk({tag, "_cnt"}, 128'(wr_outstanding), 128'(0));
        chk({tag, "_nohaz"}, 128'(ci0_nohazards_wr_all), 128'(1));
        chk({tag, "_err"}, 128'(err_underflow), 128'(0));
        chk({tag, "_rdy"}, 128'(req_ready), 128'(0));
        chk({tag, "_rsp"}, 128'(rsp_wrvalid), 128'(0));
        chk({tag, "_pstall"}, 128'(perf_stall_cnt), 128'(0));
        chk({tag, "_pbeat"}, 128'(perf_beat_cnt), 128'(0));
    endtask

    initial begin
        int c0, c1, af_wv;
        reset_reset          = 1'b1;
        req_valid            = '0;
        req_last             = '0;
        req_header           = '0;
        req_data             = '0;
        req_byteen           = '0;
        ci0_tx_c1_almostfull = 1'b0;
        ci0_rx_c1_header     = '0;
        ci0_rx_c1_wrvalid    = 1'b0;
        repeat (2) @(posedge clk_clk);
        #1;
        chk_reset_vals("rst0");
        reset_reset = 1'b0;
        tick();

        // Two requesters, three single-line packets each: strict alternation
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < 6; k++) begin
            set_beat(0, c0, c0 < 3, 1'b1);
            set_beat(1, 10 + c1, c1 < 3, 1'b1);
            #1;
            chk("s1_rdy", 128'(req_ready), (k % 2 == 0) ? 128'(1) : 128'(2));
            tick();
            if (k % 2 == 0) begin
                chk_tx("s1_tx", 0, c0);
                c0++;
            end else begin
                chk_tx("s1_tx", 1, 10 + c1);
                c1++;
            end
        end
        req_valid = '0;
        #1;
        chk("s1_rdy_idle", 128'(req_ready), 128'(0));
        tick();
        chk("s1_wv_idle", 128'(ci0_tx_c1_wrvalid), 128'(0));
        chk("s1_cnt", 128'(wr_outstanding), 128'(6));
        chk("s1_nohaz", 128'(ci0_nohazards_wr_all), 128'(0));
        drain(4, 0);
        drain(1, 1);
        drain(1, 3);
        chk("s1_cnt_done", 128'(wr_outstanding), 128'(0));
        chk("s1_nohaz_done", 128'(ci0_nohazards_wr_all), 128'(1));

        // Pointer moves to 1, then req0 4-beat packet holds the lock
        set_beat(0, 100, 1'b1, 1'b1);
        set_beat(1, 0, 1'b0, 1'b1);
        #1;
        chk("s2_pre_rdy", 128'(req_ready), 128'(1));
        tick();
        chk_tx("s2_pre", 0, 100);
        for (int b = 0; b < 4; b++) begin
            set_beat(0, 200 + b, 1'b1, b == 3);
            set_beat(1, 300, b > 0, 1'b1);
            #1;
            chk("s2_lock_rdy", 128'(req_ready), 128'(1));
            tick();
            chk_tx("s2_lock", 0, 200 + b);
        end
        set_beat(0, 0, 1'b0, 1'b1);
        set_beat(1, 300, 1'b1, 1'b1);
        #1;
        chk("s2_next_rdy", 128'(req_ready), 128'(2));
        tick();
        chk_tx("s2_next", 1, 300);
        req_valid = '0;
        tick();
        chk("s2_cnt", 128'(wr_outstanding), 128'(6));
        drain(6, 1);

        // Almost-full for five cycles mid-stream
        set_beat(1, 0, 1'b0, 1'b1);
        for (int a = 0; a < 2; a++) begin
            set_beat(0, 400 + a, 1'b1, 1'b1);
            #1;
            chk("s3_rdy", 128'(req_ready), 128'(1));
            tick();
            chk_tx("s3_tx", 0, 400 + a);
        end
        af_wv = 0;
        ci0_tx_c1_almostfull = 1'b1;
        set_beat(0, 402, 1'b1, 1'b1);
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("s3_af_rdy", 128'(req_ready), 128'(0));
            af_wv += int'(ci0_tx_c1_wrvalid);
            tick();
        end
        ci0_tx_c1_almostfull = 1'b0;
        #1;
        chk("s3_af_wv", 128'(af_wv), 128'(1));
        chk("s3_resume_rdy", 128'(req_ready), 128'(1));
        tick();
        chk_tx("s3_resume", 0, 402);
`ifdef CCIP_C1_WRITE_ARBITER_PERF_EN
        chk("s3_pstall", 128'(perf_stall_cnt), 128'(5));
`else
        chk("s3_pstall", 128'(perf_stall_cnt), 128'(0));
`endif
        req_valid = '0;
        tick();
        chk("s3_cnt", 128'(wr_outstanding), 128'(3));
`ifdef CCIP_C1_WRITE_ARBITER_PERF_EN
        chk("s3_pbeat", 128'(perf_beat_cnt), 128'(exp_beats));
`else
        chk("s3_pbeat", 128'(perf_beat_cnt), 128'(0));
`endif
        drain(3, 0);

        // Fill all 64 credits without completions
        for (int j = 0; j < 64; j++) begin
            set_beat(0, 500 + j, 1'b1, 1'b1);
            #1;
            chk("s4_rdy", 128'(req_ready), 128'(1));
            tick();
            chk_tx("s4_tx", 0, 500 + j);
        end
        set_beat(0, 600, 1'b1, 1'b1);
        #1;
        chk("s4_full_rdy0", 128'(req_ready), 128'(0));
        tick();
        chk("s4_full_wv", 128'(ci0_tx_c1_wrvalid), 128'(0));
        #1;
        chk("s4_full_rdy1", 128'(req_ready), 128'(0));
        chk("s4_cnt64", 128'(wr_outstanding), 128'(64));
        tick();
        ci0_rx_c1_header  = 28'h5A5_0001;
        ci0_rx_c1_wrvalid = 1'b1;
        #1;
        chk("s4_rsp1", 128'(rsp_wrvalid), 128'(2));
        chk("s4_full_rdy2", 128'(req_ready), 128'(0));
        tick();
        ci0_rx_c1_wrvalid = 1'b0;
        #1;
        chk("s4_cnt63", 128'(wr_outstanding), 128'(63));
        chk("s4_resume_rdy", 128'(req_ready), 128'(1));
        tick();
        chk_tx("s4_resume", 0, 600);
        req_valid         = '0;
        ci0_rx_c1_header  = 28'h5A5_0000;
        ci0_rx_c1_wrvalid = 1'b1;
        #1;
        chk("s4_both_rsp", 128'(rsp_wrvalid), 128'(1));
        tick();
        ci0_rx_c1_wrvalid = 1'b0;
        chk("s4_both_cnt", 128'(wr_outstanding), 128'(63));
        drain(63, 0);
        chk("s4_cnt0", 128'(wr_outstanding), 128'(0));
        chk("s4_nohaz", 128'(ci0_nohazards_wr_all), 128'(1));
        chk("s4_err0", 128'(err_underflow), 128'(0));

        // Extra completion underflows; flag is sticky
        drain(1, 0);
        chk("s5_err", 128'(err_underflow), 128'(1));
        chk("s5_cnt", 128'(wr_outstanding), 128'(0));
        chk("s5_nohaz", 128'(ci0_nohazards_wr_all), 128'(1));
        tick();
        chk("s5_err_sticky", 128'(err_underflow), 128'(1));

        // Reset during beat 2 of a req1 4-beat packet
        set_beat(1, 700, 1'b1, 1'b0);
        set_beat(0, 800, 1'b1, 1'b1);
        #1;
        chk("s6_rdy0", 128'(req_ready), 128'(2));
        tick();
        chk_tx("s6_b0", 1, 700);
        set_beat(1, 701, 1'b1, 1'b0);
        #1;
        chk("s6_rdy1", 128'(req_ready), 128'(2));
        #1;
        reset_reset = 1'b1;
        #1;
        chk_reset_vals("s6_async");
        tick();
        chk("s6_no_beat", 128'(ci0_tx_c1_wrvalid), 128'(0));
        chk("s6_rst_rdy", 128'(req_ready), 128'(0));
        reset_reset = 1'b0;
        #1;
        chk("s6_post_rdy", 128'(req_ready), 128'(1));
        tick();
        chk_tx("s6_post", 0, 800);
        req_valid = '0;
        tick();
        chk("s6_idle_wv", 128'(ci0_tx_c1_wrvalid), 128'(0));
        chk("s6_cnt", 128'(wr_outstanding), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
